// File: rtl/i2c_pkg.sv
// Shared I2C definitions: codec target FSM states, WM8731 address and register map.
package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ACK_ADDR,
    S_BYTE_HI,
    S_ACK_HI,
    S_BYTE_LO,
    S_ACK_LO,
    S_IGNORE
  } state_t;

  localparam logic [6:0] WM8731_ADDR = 7'h1A;
  localparam int         NREG        = 16;

  localparam logic [6:0] REG_LLINE  = 7'd0;
  localparam logic [6:0] REG_RLINE  = 7'd1;
  localparam logic [6:0] REG_LHP    = 7'd2;
  localparam logic [6:0] REG_RHP    = 7'd3;
  localparam logic [6:0] REG_APATH  = 7'd4;
  localparam logic [6:0] REG_DPATH  = 7'd5;
  localparam logic [6:0] REG_PDOWN  = 7'd6;
  localparam logic [6:0] REG_DFMT   = 7'd7;
  localparam logic [6:0] REG_SAMP   = 7'd8;
  localparam logic [6:0] REG_ACTIVE = 7'd9;
  localparam logic [6:0] REG_RESET  = 7'd15;

  // Address byte a controller sends to write to the given 7-bit target.
  function automatic logic [7:0] write_byte(input logic [6:0] dev);
    return {dev, 1'b0};
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA and derives SCL edge strobes plus START/STOP conditions.
module i2c_line_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_d;
  logic       sda_d;
  logic       scl_steady_high;

  // Idle bus is high, so reset to 1 to avoid a phantom edge after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], i_scl};
      sda_sync <= {sda_sync[0], i_sda};
      scl_d    <= scl_sync[1];
      sda_d    <= sda_sync[1];
    end
  end

  // An SDA edge coincident with an SCL edge is data, never START/STOP.
  assign scl_steady_high = scl_sync[1] & scl_d;

  assign o_sda      = sda_sync[1];
  assign o_scl_rise = scl_sync[1] & ~scl_d;
  assign o_scl_fall = ~scl_sync[1] & scl_d;
  assign o_start    = scl_steady_high & sda_d & ~sda_sync[1];
  assign o_stop     = scl_steady_high & ~sda_d & sda_sync[1];

endmodule

// File: rtl/i2c_codec_target.sv
// I2C write-only target for the codec control protocol with a 16-entry register file.
//
// state      | meaning
// S_IDLE     | bus idle, waiting for START
// S_ADDR     | shifting the device address byte
// S_ACK_ADDR | driving ACK for a matching address
// S_BYTE_HI  | shifting {reg_addr[6:0], data[8]}
// S_ACK_HI   | driving ACK for the high byte
// S_BYTE_LO  | shifting data[7:0]; commit on last bit
// S_ACK_LO   | driving ACK for the low byte
// S_IGNORE   | not addressed, waiting for START or STOP
module i2c_codec_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = WM8731_ADDR
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  output logic       o_busy,
  output logic       o_reg_wr,
  output logic [6:0] o_reg_addr,
  output logic [8:0] o_reg_data,
  output logic       o_soft_rst,
  output logic       o_err,
  input  logic [3:0] i_rd_addr,
  output logic [8:0] o_rd_data
);

  logic sda;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_line_sync u_line_sync (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_scl      (i_scl),
    .i_sda      (i_sda),
    .o_sda      (sda),
    .o_scl_rise (scl_rise),
    .o_scl_fall (scl_fall),
    .o_start    (start_det),
    .o_stop     (stop_det)
  );

  state_t     state, state_nx;
  logic [2:0] bit_cnt, bit_cnt_nx;
  logic [7:0] shreg, shreg_nx;
  logic [7:0] hi_byte, hi_byte_nx;
  logic       sda_oe, sda_oe_nx;
  logic       busy, busy_nx;
  logic       commit, commit_nx;
  logic [7:0] byte_in;
  logic       last_bit;
  logic [6:0] commit_addr;
  logic [8:0] commit_data;

  assign byte_in  = {shreg[6:0], sda};
  assign last_bit = (bit_cnt == 3'd0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S_IDLE;
      bit_cnt <= 3'd7;
      shreg   <= 8'h00;
      hi_byte <= 8'h00;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      commit  <= 1'b0;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_cnt_nx;
      shreg   <= shreg_nx;
      hi_byte <= hi_byte_nx;
      sda_oe  <= sda_oe_nx;
      busy    <= busy_nx;
      commit  <= commit_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    hi_byte_nx = hi_byte;
    sda_oe_nx  = sda_oe;
    busy_nx    = busy;
    commit_nx  = 1'b0;

    if (start_det) begin
      state_nx   = S_ADDR;
      bit_cnt_nx = 3'd7;
      sda_oe_nx  = 1'b0;
      busy_nx    = 1'b1;
    end else if (stop_det) begin
      state_nx  = S_IDLE;
      sda_oe_nx = 1'b0;
      busy_nx   = 1'b0;
    end else begin
      unique case (state)
        S_ADDR: begin
          if (scl_rise) begin
            shreg_nx   = byte_in;
            bit_cnt_nx = bit_cnt - 3'd1;
            if (last_bit)
              state_nx = (byte_in == write_byte(DEV_ADDR)) ? S_ACK_ADDR : S_IGNORE;
          end
        end
        S_BYTE_HI: begin
          if (scl_rise) begin
            shreg_nx   = byte_in;
            bit_cnt_nx = bit_cnt - 3'd1;
            if (last_bit) begin
              hi_byte_nx = byte_in;
              state_nx   = S_ACK_HI;
            end
          end
        end
        S_BYTE_LO: begin
          if (scl_rise) begin
            shreg_nx   = byte_in;
            bit_cnt_nx = bit_cnt - 3'd1;
            if (last_bit) begin
              commit_nx = 1'b1;
              state_nx  = S_ACK_LO;
            end
          end
        end
        // First falling edge grabs SDA, the next one (end of 9th clock) lets go.
        S_ACK_ADDR, S_ACK_HI, S_ACK_LO: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_nx = 1'b1;
            end else begin
              sda_oe_nx  = 1'b0;
              bit_cnt_nx = 3'd7;
              state_nx   = (state == S_ACK_HI) ? S_BYTE_LO : S_BYTE_HI;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // hi_byte/shreg stay stable through the commit cycle since SCL is still high.
  assign commit_addr = hi_byte[7:1];
  assign commit_data = {hi_byte[0], shreg};

  logic [8:0] regfile [NREG];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) regfile[i] <= 9'h000;
      o_reg_wr   <= 1'b0;
      o_reg_addr <= 7'h00;
      o_reg_data <= 9'h000;
      o_soft_rst <= 1'b0;
      o_err      <= 1'b0;
      o_rd_data  <= 9'h000;
    end else begin
      o_reg_wr   <= commit;
      o_soft_rst <= commit && (commit_addr == REG_RESET);
      o_rd_data  <= regfile[i_rd_addr];
      if (commit) begin
        o_reg_addr <= commit_addr;
        o_reg_data <= commit_data;
        if (commit_addr == REG_RESET) begin
          for (int i = 0; i < NREG; i++) regfile[i] <= 9'h000;
        end else if (commit_addr < 7'(NREG)) begin
          regfile[commit_addr[3:0]] <= commit_data;
        end else begin
          o_err <= 1'b1;
        end
      end
    end
  end

  assign o_sda_oe = sda_oe;
  assign o_busy   = busy;

endmodule
